// File: rtl/m_multicycle_core_if.sv
// Status bundle of the multi-cycle core: current PC, retire strobe, halt flag.
interface m_multicycle_core_if;
   logic [31:0] w_pc;
   logic        w_retire;
   logic        w_halt;

   modport master (output w_pc, output w_retire, output w_halt);
   modport slave  (input  w_pc, input  w_retire, input  w_halt);
endinterface

// File: rtl/m_multicycle_core.sv
// Multi-cycle RV32I-subset core: IF/ID/EX/MA/WB sequencer around one shared ALU,
// with word-addressed instruction and data memories held in instances imem/dmem.

// Single-port word memory: unreset array, read data held in a resettable register.
module m_multicycle_core_mem #(
   parameter int WORDS = 64
) (
   input  logic                     w_clock,
   input  logic                     w_reset,
   input  logic                     w_rd_en,
   input  logic                     w_wr_en,
   input  logic [$clog2(WORDS)-1:0] w_addr,
   input  logic [31:0]              w_wdata,
   output logic [31:0]              w_rdata
);
   logic [31:0] mem [WORDS];
   logic [31:0] r_rdata;

   // array write; contents survive reset so benches can preload them
   always_ff @(posedge w_clock) begin
      if (w_wr_en) mem[w_addr] <= w_wdata;
   end

   // read register captures the addressed word only when enabled
   always_ff @(posedge w_clock or posedge w_reset) begin
      if (w_reset)      r_rdata <= '0;
      else if (w_rd_en) r_rdata <= mem[w_addr];
   end

   assign w_rdata = r_rdata;
endmodule

module m_multicycle_core #(
   parameter int          IMEM_WORDS = 64,
   parameter int          DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          HALT_REG   = 30
) (
   input  logic          w_clock,
   input  logic          w_reset,
   m_multicycle_core_if.master bus
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);
   localparam logic [4:0] HALT_RD = 5'(HALT_REG);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MA, S_WB, S_HALT} state_t;

   state_t      r_state;
   logic [31:0] r_pc, r_a, r_b, r_imm, r_alu;
   logic        r_cond, r_retire, r_halt;
   logic [31:0] r_rf [32];
   logic [31:0] r_ir, r_mdr;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        is_addi, is_op, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;
   logic [31:0] imm, alu_a, alu_b, alu_y, pc_plus4, wb_data, pc_next;
   logic        cond, rd_we, halt_hit;

   // IR lives in the imem read register, loaded only during IF
   m_multicycle_core_mem #(.WORDS(IMEM_WORDS)) imem (
      .w_clock(w_clock), .w_reset(w_reset),
      .w_rd_en(r_state == S_IF), .w_wr_en(1'b0),
      .w_addr(r_pc[IAW+1:2]), .w_wdata(32'h0), .w_rdata(r_ir)
   );

   // MDR lives in the dmem read register; the store enable is decoded from the
   // state register, so an asynchronous reset in MA also cancels the write
   m_multicycle_core_mem #(.WORDS(DMEM_WORDS)) dmem (
      .w_clock(w_clock), .w_reset(w_reset),
      .w_rd_en(r_state == S_MA && is_lw), .w_wr_en(r_state == S_MA && is_sw),
      .w_addr(r_alu[DAW+1:2]), .w_wdata(r_b), .w_rdata(r_mdr)
   );

   assign opcode  = r_ir[6:0];
   assign rd      = r_ir[11:7];
   assign f3      = r_ir[14:12];
   assign rs1     = r_ir[19:15];
   assign rs2     = r_ir[24:20];
   assign is_addi = (opcode == OP_IMM)   && (f3 == 3'b000);
   assign is_op   = (opcode == OP_REG)   && (f3 == 3'b000);
   assign is_lw   = (opcode == OP_LOAD)  && (f3 == 3'b010);
   assign is_sw   = (opcode == OP_STORE) && (f3 == 3'b010);
   assign is_br   = (opcode == OP_BRANCH);
   assign is_jal  = (opcode == OP_JAL);
   assign is_jalr = (opcode == OP_JALR)  && (f3 == 3'b000);
   assign is_lui  = (opcode == OP_LUI);

   // immediate decode by instruction format
   always_comb begin
      imm = {{20{r_ir[31]}}, r_ir[31:20]};
      if (opcode == OP_STORE)  imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      if (opcode == OP_BRANCH) imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      if (opcode == OP_LUI)    imm = {r_ir[31:12], 12'h000};
      if (opcode == OP_JAL)    imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
   end

   // shared ALU: PC-relative targets for branch/jal, rs1 base otherwise
   always_comb begin
      alu_a = r_a;
      if (is_br || is_jal) alu_a = r_pc;
      if (is_lui)          alu_a = 32'h0;
      alu_b = is_op ? r_b : r_imm;
      alu_y = (is_op && r_ir[30]) ? alu_a - alu_b : alu_a + alu_b;
   end

   // signed branch comparison; unsupported funct3 is never taken
   always_comb begin
      cond = 1'b0;
      case (f3)
         3'b000:  cond = (r_a == r_b);
         3'b001:  cond = (r_a != r_b);
         3'b100:  cond = ($signed(r_a) <  $signed(r_b));
         3'b101:  cond = ($signed(r_a) >= $signed(r_b));
         default: cond = 1'b0;
      endcase
   end

   assign pc_plus4 = r_pc + 32'd4;
   assign rd_we    = (is_addi || is_op || is_lw || is_jal || is_jalr || is_lui) && (rd != 5'd0);
   assign halt_hit = rd_we && (rd == HALT_RD);
   assign wb_data  = is_lw ? r_mdr : ((is_jal || is_jalr) ? pc_plus4 : r_alu);
   assign pc_next  = (is_jal || (is_br && r_cond)) ? r_alu :
                     (is_jalr ? {r_alu[31:1], 1'b0} : pc_plus4);

   // sequencer with registered retire/halt outputs and register file writeback
   always_ff @(posedge w_clock or posedge w_reset) begin
      if (w_reset) begin
         r_state  <= S_IF;
         r_pc     <= RESET_PC;
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_alu    <= '0;
         r_cond   <= 1'b0;
         r_retire <= 1'b0;
         r_halt   <= 1'b0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            S_IF: r_state <= S_ID;
            S_ID: begin
               r_a     <= r_rf[rs1];
               r_b     <= r_rf[rs2];
               r_imm   <= imm;
               r_state <= S_EX;
            end
            S_EX: begin
               r_alu   <= alu_y;
               r_cond  <= cond;
               r_state <= S_MA;
            end
            S_MA: begin
               r_retire <= 1'b1;
               r_state  <= S_WB;
            end
            S_WB: begin
               if (rd_we) r_rf[rd] <= wb_data;
               r_pc <= pc_next;
               if (halt_hit) begin
                  r_halt  <= 1'b1;
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_IF;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IF;
         endcase
      end
   end

   assign bus.w_pc     = r_pc;
   assign bus.w_retire = r_retire;
   assign bus.w_halt   = r_halt;
endmodule

// File: tb/tb_m_multicycle_core.sv
// Directed bench for m_multicycle_core: single-instruction vector table plus
// hand-written multi-instruction sequences (loop/halt, memory, jumps, reset in MA).
module tb_m_multicycle_core;
   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] OPL = 7'b0000011;
   localparam logic [6:0] OPU = 7'b0110111;
   localparam logic [6:0] OPJR = 7'b1100111;

   logic w_clock = 1'b0;
   logic w_reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   ret_cnt;
   int   cyc;
   logic [31:0] ret_pc [16];
   logic [31:0] prog [16];
   logic [2:0]  st;

   typedef struct {
      logic [31:0] instr;
      int          a;
      int          b;
      logic [31:0] exp_x3;
      logic [31:0] exp_x4;
   } vec_t;
   vec_t vecs [13];

   m_multicycle_core_if bus_if ();

   m_multicycle_core #(
      .IMEM_WORDS(64), .DMEM_WORDS(64), .RESET_PC(32'h0), .HALT_REG(30)
   ) dut (
      .w_clock(w_clock), .w_reset(w_reset), .bus(bus_if)
   );

   always #5 w_clock = ~w_clock;

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], 3'b000, rd[4:0], OPR};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd);
      return {imm20[19:0], rd[4:0], OPU};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 32'h0;
   endtask

   // assert reset at a negedge and load memories while the core is held
   task automatic begin_reset();
      @(negedge w_clock);
      w_reset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         dut.imem.mem[i] = (i < 16) ? prog[i] : 32'h0;
         dut.dmem.mem[i] = 32'h0;
      end
   endtask

   task automatic release_reset();
      @(negedge w_clock);
      w_reset = 1'b0;
   endtask

   // advance max_cyc posedges, sampling at each following negedge
   task automatic run(input int max_cyc, input bit stop_halt);
      ret_cnt = 0;
      cyc = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge w_clock);
         @(negedge w_clock);
         cyc++;
         if (bus_if.w_retire) begin
            if (ret_cnt < 16) ret_pc[ret_cnt] = bus_if.w_pc;
            ret_cnt++;
         end
         if (stop_halt && bus_if.w_halt) break;
      end
   endtask

   initial begin
      // table: x1=a, x2=b, test instr at PC 8, x4<-1 at PC 12, halt at PC 16
      vecs[0]  = '{enc_r(0, 2, 1, 3),          5,     7, 32'h0000000C, 32'd1};
      vecs[1]  = '{enc_r(32, 2, 1, 3),         5,     7, 32'hFFFFFFFE, 32'd1};
      vecs[2]  = '{enc_i(-1, 1, 0, 3, OPI),    0,     0, 32'hFFFFFFFF, 32'd1};
      vecs[3]  = '{enc_r(32, 2, 1, 3),     -2048,     1, 32'hFFFFF7FF, 32'd1};
      vecs[4]  = '{enc_b(8, 2, 1, 4),         -1,     1, 32'h0,        32'd0};
      vecs[5]  = '{enc_b(8, 2, 1, 5),         -1,     1, 32'h0,        32'd1};
      vecs[6]  = '{enc_b(8, 1, 1, 0),         -1,     1, 32'h0,        32'd0};
      vecs[7]  = '{enc_b(8, 2, 1, 1),          3,     3, 32'h0,        32'd1};
      vecs[8]  = '{enc_b(8, 2, 1, 5),          3,     3, 32'h0,        32'd0};
      vecs[9]  = '{enc_b(8, 2, 1, 4),          1,    -1, 32'h0,        32'd1};
      vecs[10] = '{enc_u(32'h12345, 3),        0,     0, 32'h12345000, 32'd1};
      vecs[11] = '{enc_i(5, 0, 0, 0, OPI),     0,     0, 32'h0,        32'd1};
      vecs[12] = '{32'h000001FF,               0,     0, 32'h0,        32'd1};

      // reset state
      clear_prog();
      begin_reset();
      #1;
      st = dut.r_state;
      check("reset_pc", bus_if.w_pc, 32'h0);
      check("reset_retire", {31'b0, bus_if.w_retire}, 32'd0);
      check("reset_halt", {31'b0, bus_if.w_halt}, 32'd0);
      check("reset_state", {29'b0, st}, 32'd0);

      // loop program with halt via x30
      clear_prog();
      prog[0] = enc_i(5, 0, 0, 1, OPI);
      prog[1] = enc_r(0, 1, 1, 2);
      prog[2] = enc_i(1, 1, 0, 1, OPI);
      prog[3] = enc_b(-4, 2, 1, 1);
      prog[4] = enc_i(9, 0, 0, 30, OPI);
      begin_reset();
      release_reset();
      run(200, 1'b1);
      check("loop_halt_cycle", cyc, 32'd65);
      check("loop_retires", ret_cnt, 32'd13);
      check("loop_x1", dut.r_rf[1], 32'd10);
      check("loop_x2", dut.r_rf[2], 32'd10);
      check("loop_x30", dut.r_rf[30], 32'd9);
      run(10, 1'b0);
      st = dut.r_state;
      check("halted_no_retire", ret_cnt, 32'd0);
      check("halted_halt_held", {31'b0, bus_if.w_halt}, 32'd1);
      check("halted_state", {29'b0, st}, 32'd5);

      // memory round trip with address wrap
      clear_prog();
      prog[0] = enc_i(-7, 0, 0, 5, OPI);
      prog[1] = enc_s(8, 5, 0);
      prog[2] = enc_i(8, 0, 2, 6, OPL);
      prog[3] = enc_i(264, 0, 2, 7, OPL);
      prog[4] = enc_i(1, 0, 0, 30, OPI);
      begin_reset();
      #1;
      check("halt_cleared_by_reset", {31'b0, bus_if.w_halt}, 32'd0);
      release_reset();
      run(100, 1'b1);
      check("mem_x6", dut.r_rf[6], 32'hFFFFFFF9);
      check("mem_x7_wrap", dut.r_rf[7], 32'hFFFFFFF9);
      check("mem_dmem2", dut.dmem.mem[2], 32'hFFFFFFF9);

      // jal / jalr / lui
      clear_prog();
      prog[0] = enc_j(8, 1);
      prog[1] = enc_u(32'h12345, 3);
      prog[2] = enc_i(0, 1, 0, 0, OPJR);
      begin_reset();
      release_reset();
      run(20, 1'b0);
      check("jmp_retires", ret_cnt, 32'd4);
      check("jmp_pc0", ret_pc[0], 32'h0);
      check("jmp_pc1", ret_pc[1], 32'h8);
      check("jmp_pc2", ret_pc[2], 32'h4);
      check("jmp_pc_end", bus_if.w_pc, 32'h4);
      check("jmp_x1", dut.r_rf[1], 32'h4);
      check("jmp_x3", dut.r_rf[3], 32'h12345000);

      // x0 write dropped, unknown opcode is a no-op
      clear_prog();
      prog[0] = enc_i(5, 0, 0, 0, OPI);
      prog[1] = 32'h0000007F;
      begin_reset();
      release_reset();
      run(10, 1'b0);
      check("nop_x0", dut.r_rf[0], 32'h0);
      check("nop_retire_pc1", ret_pc[1], 32'h4);
      check("nop_pc", bus_if.w_pc, 32'h8);
      check("nop_halt", {31'b0, bus_if.w_halt}, 32'd0);

      // asynchronous reset while a sw sits in MA
      clear_prog();
      prog[0] = enc_i(-7, 0, 0, 5, OPI);
      prog[1] = enc_s(12, 5, 0);
      begin_reset();
      dut.dmem.mem[3] = 32'hA5A5A5A5;
      release_reset();
      run(8, 1'b0);
      st = dut.r_state;
      check("rst_ma_state_before", {29'b0, st}, 32'd3);
      check("rst_ma_pc_before", bus_if.w_pc, 32'h4);
      w_reset = 1'b1;
      #1;
      st = dut.r_state;
      check("rst_ma_pc_async", bus_if.w_pc, 32'h0);
      check("rst_ma_state_async", {29'b0, st}, 32'd0);
      @(negedge w_clock);
      @(negedge w_clock);
      check("rst_ma_dmem_kept", dut.dmem.mem[3], 32'hA5A5A5A5);
      w_reset = 1'b0;
      run(10, 1'b0);
      check("rst_ma_restart_pc0", ret_pc[0], 32'h0);
      check("rst_ma_pc_after", bus_if.w_pc, 32'h8);
      check("rst_ma_dmem_stored", dut.dmem.mem[3], 32'hFFFFFFF9);

      // single-instruction vector table
      for (int k = 0; k < 13; k++) begin
         clear_prog();
         prog[0] = enc_i(vecs[k].a, 0, 0, 1, OPI);
         prog[1] = enc_i(vecs[k].b, 0, 0, 2, OPI);
         prog[2] = vecs[k].instr;
         prog[3] = enc_i(1, 0, 0, 4, OPI);
         prog[4] = enc_i(1, 0, 0, 30, OPI);
         begin_reset();
         release_reset();
         run(100, 1'b1);
         check($sformatf("vec%0d_x3", k), dut.r_rf[3], vecs[k].exp_x3);
         check($sformatf("vec%0d_x4", k), dut.r_rf[4], vecs[k].exp_x4);
         check($sformatf("vec%0d_retires", k), ret_cnt, (vecs[k].exp_x4 != 0) ? 32'd5 : 32'd4);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
